// File: rtl/usb_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : usb_tx_sequencer
// Purpose  : Transmit scheduler in front of the bit-stuffer. Picks one of the
//            handshake/token/data sources, shifts the packet out LSB-first
//            with its type code, waits for the stuffer to drain, then drives
//            EOP and an inter-packet gap before the next grant.
// Revision : 1.0 - initial release
// ============================================================================
module usb_tx_sequencer #(
  parameter int EOP_CYCLES    = 2,
  parameter int GAP_CYCLES    = 2,
  parameter int DRAIN_TIMEOUT = 31
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic [2:0]  req,
  input  logic [15:0] pkt_hs,
  input  logic [31:0] pkt_tok,
  input  logic [95:0] pkt_data,
  input  logic        abort,
  output logic [2:0]  ack,
  output logic        stf_bit,
  output logic [1:0]  stf_type,
  input  logic [1:0]  stf_busy,
  input  logic [5:0]  stf_stuffed,
  output logic        eop,
  output logic        done,
  output logic [5:0]  last_stuffed,
  output logic        err_timeout
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SEND  = 3'd1;
  localparam logic [2:0] S_DRAIN = 3'd2;
  localparam logic [2:0] S_EOP   = 3'd3;
  localparam logic [2:0] S_GAP   = 3'd4;

  localparam logic [1:0] c_type_idle = 2'b00;
  localparam logic [1:0] c_type_tok  = 2'b01;
  localparam logic [1:0] c_type_data = 2'b10;
  localparam logic [1:0] c_type_hs   = 2'b11;

  localparam logic [4:0] c_timeout    = 5'(DRAIN_TIMEOUT);
  localparam logic [4:0] c_timeout_m1 = 5'(DRAIN_TIMEOUT - 1);
  localparam logic [7:0] c_eop_last   = 8'(EOP_CYCLES - 1);
  localparam logic [7:0] c_gap_last   = 8'(GAP_CYCLES - 1);

  logic [2:0]  r_state;
  logic [95:0] r_sreg;
  logic [6:0]  r_bitcnt;
  logic [1:0]  r_type;
  logic [4:0]  r_timer;
  logic [7:0]  r_tcnt;
  logic        r_done;
  logic [5:0]  r_last_stuffed;
  logic        r_err;

  logic [2:0]  w_grant;
  logic [95:0] w_pkt;
  logic [6:0]  w_len_m1;
  logic [1:0]  w_type;

  // Fixed-priority selection: handshake beats token beats data.
  always_comb begin
    w_grant  = 3'b000;
    w_pkt    = '0;
    w_len_m1 = 7'd0;
    w_type   = c_type_idle;
    if (req[0]) begin
      w_grant  = 3'b001;
      w_pkt    = {80'd0, pkt_hs};
      w_len_m1 = 7'd15;
      w_type   = c_type_hs;
    end else if (req[1]) begin
      w_grant  = 3'b010;
      w_pkt    = {64'd0, pkt_tok};
      w_len_m1 = 7'd31;
      w_type   = c_type_tok;
    end else if (req[2]) begin
      w_grant  = 3'b100;
      w_pkt    = pkt_data;
      w_len_m1 = 7'd95;
      w_type   = c_type_data;
    end
  end

  // Grant is only offered from IDLE; rst_b gating keeps ack quiet during reset.
  assign ack          = (rst_b && (r_state == S_IDLE)) ? w_grant : 3'b000;
  assign stf_bit      = (r_state == S_SEND) ? r_sreg[0] : 1'b0;
  assign stf_type     = (r_state == S_SEND) ? r_type : c_type_idle;
  assign eop          = (r_state == S_EOP);
  assign done         = r_done;
  assign last_stuffed = r_last_stuffed;
  assign err_timeout  = r_err;

  // Packet sequencing FSM with shift register, bit counter and phase timers.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      r_state        <= S_IDLE;
      r_sreg         <= '0;
      r_bitcnt       <= 7'd0;
      r_type         <= c_type_idle;
      r_timer        <= 5'd0;
      r_tcnt         <= 8'd0;
      r_done         <= 1'b0;
      r_last_stuffed <= 6'd0;
      r_err          <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_grant != 3'b000) begin
            r_sreg   <= w_pkt;
            r_bitcnt <= w_len_m1;
            r_type   <= w_type;
            r_timer  <= 5'd0;
            r_err    <= 1'b0;
            r_state  <= S_SEND;
          end
        end
        S_SEND: begin
          r_sreg <= {1'b0, r_sreg[95:1]};
          if (r_bitcnt != 7'd0) begin
            r_bitcnt <= r_bitcnt - 7'd1;
          end
          // Abort takes precedence over the final-bit transition.
          if (abort) begin
            r_tcnt  <= 8'd0;
            r_state <= S_GAP;
          end else if (r_bitcnt == 7'd0) begin
            r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (abort) begin
            r_tcnt  <= 8'd0;
            r_state <= S_GAP;
          end else if (stf_busy == 2'b00) begin
            r_last_stuffed <= stf_stuffed;
            r_tcnt         <= 8'd0;
            r_state        <= S_EOP;
          end else begin
            if (r_timer != c_timeout) begin
              r_timer <= r_timer + 5'd1;
            end
            // The increment in this cycle reaches the limit: give up waiting.
            if (r_timer >= c_timeout_m1) begin
              r_err          <= 1'b1;
              r_last_stuffed <= stf_stuffed;
              r_tcnt         <= 8'd0;
              r_state        <= S_EOP;
            end
          end
        end
        S_EOP: begin
          if (r_tcnt == c_eop_last) begin
            r_done  <= 1'b1;
            r_tcnt  <= 8'd0;
            r_state <= S_GAP;
          end else begin
            r_tcnt <= r_tcnt + 8'd1;
          end
        end
        S_GAP: begin
          if (r_tcnt == c_gap_last) begin
            r_state <= S_IDLE;
          end else begin
            r_tcnt <= r_tcnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_usb_tx_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_tx_sequencer
// Purpose  : Scoreboard bench for usb_tx_sequencer. Stimulus pushes expected
//            acks, serial bits and end-of-packet summaries; a monitor pops
//            and compares them as the DUT produces them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_tx_sequencer;

  logic        clk = 1'b0;
  logic        rst_b;
  logic [2:0]  req;
  logic [15:0] pkt_hs;
  logic [31:0] pkt_tok;
  logic [95:0] pkt_data;
  logic        abort;
  logic [2:0]  ack;
  logic        stf_bit;
  logic [1:0]  stf_type;
  logic [1:0]  stf_busy;
  logic [5:0]  stf_stuffed;
  logic        eop;
  logic        done;
  logic [5:0]  last_stuffed;
  logic        err_timeout;

  always #5 clk = ~clk;

  usb_tx_sequencer dut (
    .clk(clk), .rst_b(rst_b), .req(req), .pkt_hs(pkt_hs), .pkt_tok(pkt_tok),
    .pkt_data(pkt_data), .abort(abort), .ack(ack), .stf_bit(stf_bit),
    .stf_type(stf_type), .stf_busy(stf_busy), .stf_stuffed(stf_stuffed),
    .eop(eop), .done(done), .last_stuffed(last_stuffed), .err_timeout(err_timeout)
  );

  localparam logic [1:0] K_ACK  = 2'd0;
  localparam logic [1:0] K_BIT  = 2'd1;
  localparam logic [1:0] K_DONE = 2'd2;

  typedef struct packed {
    logic [1:0]  kind;
    logic [15:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  // Stuffer model: mode 0 never busy, mode 1 busy one cycle per stuffed zero,
  // mode 2 busy stuck at 10.
  int run_len = 0;
  int stuff_cnt = 0;
  int pend = 0;
  int mode = 0;

  assign stf_stuffed = 6'(stuff_cnt);
  assign stf_busy    = (mode == 2) ? 2'b10 : ((mode == 1 && pend != 0) ? 2'b10 : 2'b00);

  // Stuffer model update, sampled away from the active edge.
  always @(negedge clk) begin
    if (!rst_b) begin
      run_len = 0; stuff_cnt = 0; pend = 0;
    end else begin
      if (ack != 3'b000) begin
        run_len = 0; stuff_cnt = 0;
      end
      if (stf_type != 2'b00) begin
        if (stf_bit) begin
          run_len++;
          if (run_len == 6) begin
            stuff_cnt++;
            run_len = 0;
          end
        end else begin
          run_len = 0;
        end
        pend = stuff_cnt;
      end else if (pend != 0) begin
        pend--;
      end
    end
  end

  function automatic string kname(input logic [1:0] k);
    case (k)
      K_ACK:   return "ack";
      K_BIT:   return "bit";
      K_DONE:  return "done";
      default: return "unknown";
    endcase
  endfunction

  task automatic push(input logic [1:0] kind, input logic [15:0] val);
    exp_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Expected ack, serial bits LSB-first, optional summary {drain,eop,stuffed,err}.
  task automatic push_pkt(input logic [2:0] a, input logic [95:0] pkt, input int len,
                          input logic [1:0] ty, input logic [5:0] drain,
                          input logic [5:0] stuffed, input logic err, input bit with_done);
    push(K_ACK, {13'd0, a});
    for (int i = 0; i < len; i++) push(K_BIT, {13'd0, ty, pkt[i]});
    if (with_done) push(K_DONE, {drain, 3'd2, stuffed, err});
  endtask

  task automatic sb_check(input logic [1:0] kind, input logic [15:0] val);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected output val=%h (nothing expected)", kname(kind), val);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || e.val != val) begin
        errors++;
        $display("FAIL %s got %s val=%h, expected %s val=%h",
                 kname(kind), kname(kind), val, kname(e.kind), e.val);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", name, got, expv);
    end
  endtask

  // Monitor: compares every DUT output event against the scoreboard.
  int ph = 0, dcnt = 0, ecnt = 0;
  always @(negedge clk) begin
    if (!rst_b) begin
      ph = 0; dcnt = 0; ecnt = 0;
    end else begin
      if (ack != 3'b000) begin
        sb_check(K_ACK, {13'd0, ack});
        ph = 0; dcnt = 0; ecnt = 0;
      end
      if (stf_type != 2'b00) begin
        sb_check(K_BIT, {13'd0, stf_type, stf_bit});
        ph = 1;
      end else if (ph != 0) begin
        if (eop) ecnt++;
        else if (ecnt == 0 && dcnt < 63) dcnt++;
      end
      if (done) begin
        sb_check(K_DONE, {6'(dcnt), 3'(ecnt), last_stuffed, err_timeout});
        ph = 0; dcnt = 0; ecnt = 0;
      end
    end
  end

  // Drive until all expectations are consumed; each source drops req after its ack.
  task automatic run(input int budget);
    int n;
    logic [2:0] a;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      a = ack;
      @(posedge clk); #1;
      req = req & ~a;
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL run_timeout got=%0d pending expected=0 pending", exp_q.size());
      exp_q.delete();
    end
    req = 3'b000;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input string name);
    int n;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      if (ack != 3'b000) break;
      n++;
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL %s got=no_ack expected=ack within 20 cycles", name);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ack"}, {29'd0, ack}, 32'd0);
    chk({tag, "_stf_bit"}, {31'd0, stf_bit}, 32'd0);
    chk({tag, "_stf_type"}, {30'd0, stf_type}, 32'd0);
    chk({tag, "_eop"}, {31'd0, eop}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_last_stuffed"}, {26'd0, last_stuffed}, 32'd0);
    chk({tag, "_err_timeout"}, {31'd0, err_timeout}, 32'd0);
  endtask

  localparam logic [15:0] HS   = 16'hD280;
  localparam logic [31:0] TOK  = 32'hA5C3_2D80;
  localparam logic [95:0] DAT  = 96'h0123_4567_89AB_CDEF_0011_2233;
  localparam logic [95:0] ONES = {96{1'b1}};

  initial begin
    int  n;
    bit  eop_seen;
    bit  done_seen;
    rst_b = 1'b0; req = 3'b000; abort = 1'b0;
    pkt_hs = 16'd0; pkt_tok = 32'd0; pkt_data = 96'd0;
    repeat (3) @(posedge clk);
    #1;
    req = 3'b001;
    #1;
    check_reset_outputs("reset");
    req = 3'b000;
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;

    // Single handshake packet.
    mode = 0; pkt_hs = HS;
    push_pkt(3'b001, {80'd0, HS}, 16, 2'b11, 6'd1, 6'd0, 1'b0, 1'b1);
    req = 3'b001;
    run(100);

    // All three sources held: priority order over successive packets.
    mode = 1; pkt_tok = TOK; pkt_data = DAT;
    push_pkt(3'b001, {80'd0, HS},  16, 2'b11, 6'd1, 6'd0, 1'b0, 1'b1);
    push_pkt(3'b010, {64'd0, TOK}, 32, 2'b01, 6'd1, 6'd0, 1'b0, 1'b1);
    push_pkt(3'b100, DAT,          96, 2'b10, 6'd1, 6'd0, 1'b0, 1'b1);
    req = 3'b111;
    run(400);

    // All-ones data: 96 ones -> 16 stuffed zeros, drain while stuffer is busy.
    mode = 1; pkt_data = ONES;
    push_pkt(3'b100, ONES, 96, 2'b10, 6'd16, 6'd16, 1'b0, 1'b1);
    req = 3'b100;
    run(300);
    chk("all_ones_err_timeout", {31'd0, err_timeout}, 32'd0);
    chk("all_ones_last_stuffed", {26'd0, last_stuffed}, 32'd16);

    // Reset asserted in the fourth DRAIN cycle.
    mode = 2;
    push_pkt(3'b001, {80'd0, HS}, 16, 2'b11, 6'd0, 6'd0, 1'b0, 1'b0);
    req = 3'b001;
    wait_ack("rst_test_ack");
    @(posedge clk); #1;
    req = 3'b000;
    repeat (19) @(posedge clk);
    #1;
    chk("rst_test_bits_consumed", exp_q.size(), 32'd0);
    chk("rst_test_in_drain_eop", {31'd0, eop}, 32'd0);
    rst_b = 1'b0;
    #1;
    check_reset_outputs("mid_drain_reset");
    @(posedge clk); #1;
    rst_b = 1'b1;
    mode = 0;
    @(posedge clk); #1;
    push_pkt(3'b010, {64'd0, TOK}, 32, 2'b01, 6'd1, 6'd0, 1'b0, 1'b1);
    req = 3'b010;
    run(200);

    // Stuffer stuck busy: 31 DRAIN cycles, sticky timeout, eop still issued.
    mode = 2;
    push_pkt(3'b001, {80'd0, HS}, 16, 2'b11, 6'd31, 6'd0, 1'b1, 1'b1);
    req = 3'b001;
    run(200);
    chk("timeout_sticky", {31'd0, err_timeout}, 32'd1);
    mode = 0;

    // Abort at token bit 10 with a handshake pending behind it.
    push_pkt(3'b010, {64'd0, TOK}, 11, 2'b01, 6'd0, 6'd0, 1'b0, 1'b0);
    push_pkt(3'b001, {80'd0, HS},  16, 2'b11, 6'd1, 6'd0, 1'b0, 1'b1);
    req = 3'b010;
    wait_ack("abort_test_ack");
    @(posedge clk); #1;
    req = 3'b001;
    chk("timeout_cleared_on_ack", {31'd0, err_timeout}, 32'd0);
    repeat (10) @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    chk("type_after_abort", {30'd0, stf_type}, 32'd0);
    n = 0; eop_seen = 1'b0; done_seen = 1'b0;
    while (n < 10) begin
      @(negedge clk);
      n++;
      if (eop) eop_seen = 1'b1;
      if (done) done_seen = 1'b1;
      if (ack != 3'b000) break;
    end
    chk("abort_to_next_ack_cycles", n, 32'd3);
    chk("abort_no_eop", {31'd0, eop_seen}, 32'd0);
    chk("abort_no_done", {31'd0, done_seen}, 32'd0);
    @(posedge clk); #1;
    req = 3'b000;
    run(200);

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
